// File: rtl/mux_arb_pkg.sv
// Shared constants, FSM state type and one-hot helper for the round-robin mux arbiter.
package mux_arb_pkg;

    localparam int NREQ     = 4;
    localparam int SEL_W    = 2;
    localparam int SETTLE_W = 4;
    localparam int HOLD_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        BUSY   = 2'd2
    } state_t;

    function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request bit at or after ptr, wrapping modulo NREQ.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [SEL_W-1:0] cand [NREQ];
    logic [NREQ-1:0]  rot;

    // rot[gi] is the request seen gi places after the pointer
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rot
            assign cand[gi] = ptr + SEL_W'(gi);
            assign rot[gi]  = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        idx   = ptr;
        found = |rot;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx = cand[i];
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared 4:1 mux: drives the select lines, waits for settling, then flags valid.
// Optional grant timeout with preemption is enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int MAX_HOLD      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       addr0,
    output logic       addr1,
    output logic       sel_valid,
    output logic       busy,
    output logic       preempt
);

    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES);

    state_t              state_reg, state_next;
    logic [SEL_W-1:0]    ptr_reg, ptr_next;
    logic [SEL_W-1:0]    sel_reg, sel_next;
    logic [NREQ-1:0]     grant_reg, grant_next;
    logic                valid_reg, valid_next;
    logic [SETTLE_W-1:0] settle_reg, settle_next;
    logic [SEL_W-1:0]    pick_idx;
    logic                pick_found;
    logic                drop;
    logic                force_rel;

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign drop = ~req[sel_reg];

`ifdef MUX_ARB_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              preempt_reg;

    // Only revoke when someone else is actually waiting; otherwise keep serving.
    assign force_rel = (state_reg == BUSY) && !drop && (hold_reg >= HOLD_LIM)
                       && |(req & ~grant_reg);

    always_comb begin
        hold_next = hold_reg;
        if (state_reg == IDLE) begin
            hold_next = '0;
        end else if (state_reg == BUSY && hold_reg != '1) begin
            hold_next = hold_reg + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_reg    <= '0;
            preempt_reg <= 1'b0;
        end else begin
            hold_reg    <= hold_next;
            preempt_reg <= force_rel;
        end
    end

    assign preempt = preempt_reg;
`else
    assign force_rel = 1'b0;
    assign preempt   = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        sel_next    = sel_reg;
        grant_next  = grant_reg;
        valid_next  = valid_reg;
        settle_next = settle_reg;
        case (state_reg)
            IDLE: begin
                // sel only moves here, so the mux never sees a select change while valid
                if (pick_found) begin
                    grant_next  = onehot(pick_idx);
                    sel_next    = pick_idx;
                    settle_next = SETTLE_INIT;
                    if (SETTLE_CYCLES == 0) begin
                        state_next = BUSY;
                        valid_next = 1'b1;
                    end else begin
                        state_next = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (drop) begin
                    state_next = IDLE;
                    grant_next = '0;
                    valid_next = 1'b0;
                    ptr_next   = sel_reg + SEL_W'(1);
                end else if (settle_reg <= SETTLE_W'(1)) begin
                    state_next  = BUSY;
                    valid_next  = 1'b1;
                    settle_next = '0;
                end else begin
                    settle_next = settle_reg - SETTLE_W'(1);
                end
            end
            BUSY: begin
                if (drop || force_rel) begin
                    state_next = IDLE;
                    grant_next = '0;
                    valid_next = 1'b0;
                    ptr_next   = sel_reg + SEL_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            sel_reg    <= '0;
            grant_reg  <= '0;
            valid_reg  <= 1'b0;
            settle_reg <= '0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            sel_reg    <= sel_next;
            grant_reg  <= grant_next;
            valid_reg  <= valid_next;
            settle_reg <= settle_next;
        end
    end

    assign grant     = grant_reg;
    assign addr0     = sel_reg[0];
    assign addr1     = sel_reg[1];
    assign sel_valid = valid_reg;
    assign busy      = |grant_reg;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scenario bench for mux_rr_arbiter; a second instance with a 3-cycle settle covers the abandoned-settle case.
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic       addr0, addr1, sel_valid, busy, preempt;

    logic       reset3;
    logic [3:0] req3;
    logic [3:0] grant3;
    logic       addr0_3, addr1_3, sel_valid3, busy3, preempt3;

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    mux_rr_arbiter #(.SETTLE_CYCLES(1), .MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset), .req(req), .grant(grant),
        .addr0(addr0), .addr1(addr1), .sel_valid(sel_valid),
        .busy(busy), .preempt(preempt)
    );

    mux_rr_arbiter #(.SETTLE_CYCLES(3), .MAX_HOLD(4)) dut_s3 (
        .clk(clk), .reset(reset3), .req(req3), .grant(grant3),
        .addr0(addr0_3), .addr1(addr1_3), .sel_valid(sel_valid3),
        .busy(busy3), .preempt(preempt3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int limit, output logic ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n <= limit) begin
            if (grant != 4'b0000) ok = 1'b1;
            else begin
                tick();
                n++;
            end
        end
    endtask

    task automatic wait_valid(input int limit, output logic ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n <= limit) begin
            if (sel_valid) ok = 1'b1;
            else begin
                tick();
                n++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 4'b0000;
        reset3 = 1'b1; req3 = 4'b0000;
        tick(); tick();
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b want=0000", grant); end
        checks++; if ({addr1, addr0} !== 2'b00) begin failures++; $display("FAIL reset_addr got=%b want=00", {addr1, addr0}); end
        checks++; if (sel_valid !== 1'b0) begin failures++; $display("FAIL reset_sel_valid got=%b want=0", sel_valid); end
        checks++; if (busy !== 1'b0 || preempt !== 1'b0) begin failures++; $display("FAIL reset_busy_preempt got=%b%b want=00", busy, preempt); end
        checks++; if (grant3 !== 4'b0000) begin failures++; $display("FAIL reset_grant3 got=%b want=0000", grant3); end
        reset = 1'b0; reset3 = 1'b0;
        tick();
        $display("test_reset done grant=%b addr=%b", grant, {addr1, addr0});
    endtask

    task automatic test_rotation();
        logic       ok;
        logic [3:0] exp;
        int         k;
        exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            k = n % 4;
            wait_grant(4, ok);
            checks++; if (!ok) begin failures++; $display("FAIL rot_grant_timeout n=%0d got=%b want=nonzero", n, grant); end
            exp = exp_q.pop_front();
            checks++; if (grant !== exp) begin failures++; $display("FAIL rot_grant n=%0d got=%b want=%b", n, grant, exp); end
            checks++; if ({addr1, addr0} !== k[1:0]) begin failures++; $display("FAIL rot_addr n=%0d got=%b want=%b", n, {addr1, addr0}, k[1:0]); end
            wait_valid(4, ok);
            checks++; if (!ok) begin failures++; $display("FAIL rot_valid_timeout n=%0d got=%b want=1", n, sel_valid); end
            repeat (3) tick();
            req[k] = 1'b0;
            tick();
            checks++; if (grant !== 4'b0000 || sel_valid !== 1'b0) begin failures++; $display("FAIL rot_idle_gap n=%0d got=%b/%b want=0000/0", n, grant, sel_valid); end
            $display("rotation grant %0d served=%b", n, exp);
            req[k] = 1'b1;
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_single_grant();
        logic [3:0] exp;
        req = 4'b0001;
        exp_q.push_back(4'b0001);
        tick();
        exp = exp_q.pop_front();
        checks++; if (grant !== exp) begin failures++; $display("FAIL single_grant got=%b want=%b", grant, exp); end
        checks++; if ({addr1, addr0} !== 2'b00) begin failures++; $display("FAIL single_addr got=%b want=00", {addr1, addr0}); end
        checks++; if (sel_valid !== 1'b0) begin failures++; $display("FAIL single_settle_valid got=%b want=0", sel_valid); end
        tick();
        checks++; if (sel_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL single_valid got=%b%b want=11", sel_valid, busy); end
        req = 4'b0000;
        tick();
        checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL single_release got=%b want=0000", grant); end
        $display("test_single_grant served=%b", exp);
    endtask

    task automatic test_ptr_skip();
        logic [3:0] exp;
        req = 4'b0010;
        tick();
        checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL skip_first got=%b want=0010", grant); end
        tick();
        req = 4'b0000;
        tick();
        req = 4'b0011;
        exp_q.push_back(4'b0001);
        tick();
        exp = exp_q.pop_front();
        checks++; if (grant !== exp) begin failures++; $display("FAIL skip_grant got=%b want=%b", grant, exp); end
        checks++; if ({addr1, addr0} !== 2'b00) begin failures++; $display("FAIL skip_addr got=%b want=00", {addr1, addr0}); end
        req = 4'b0000;
        tick();
        $display("test_ptr_skip served=%b", exp);
    endtask

    task automatic test_settle_drop();
        logic seen_valid;
        seen_valid = 1'b0;
        req3 = 4'b0100;
        tick();
        seen_valid |= sel_valid3;
        checks++; if (grant3 !== 4'b0100) begin failures++; $display("FAIL drop_grant got=%b want=0100", grant3); end
        checks++; if ({addr1_3, addr0_3} !== 2'b10) begin failures++; $display("FAIL drop_addr got=%b want=10", {addr1_3, addr0_3}); end
        tick();
        seen_valid |= sel_valid3;
        req3 = 4'b0000;
        tick();
        seen_valid |= sel_valid3;
        checks++; if (grant3 !== 4'b0000) begin failures++; $display("FAIL drop_release got=%b want=0000", grant3); end
        checks++; if (seen_valid !== 1'b0) begin failures++; $display("FAIL drop_sel_valid got=%b want=0", seen_valid); end
        req3 = 4'b1111;
        exp_q.push_back(4'b1000);
        tick();
        checks++; if (grant3 !== exp_q[0]) begin failures++; $display("FAIL drop_ptr_next got=%b want=%b", grant3, exp_q[0]); end
        void'(exp_q.pop_front());
        req3 = 4'b0000;
        tick();
        $display("test_settle_drop next_grant=1000");
    endtask

    task automatic test_hold();
        logic [3:0] exp;
        req = 4'b0001;
        exp_q.push_back(4'b0001);
        tick();
        exp = exp_q.pop_front();
        checks++; if (grant !== exp) begin failures++; $display("FAIL hold_grant got=%b want=%b", grant, exp); end
        tick();
        req = 4'b0101;
`ifdef MUX_ARB_TIMEOUT_EN
        begin
            logic seen;
            seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                tick();
                if (preempt) seen = 1'b1;
            end
            checks++; if (!seen) begin failures++; $display("FAIL hold_preempt_timeout got=0 want=1"); end
            checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL hold_preempt_grant got=%b want=0000", grant); end
            tick();
            checks++; if (grant !== 4'b0100 || {addr1, addr0} !== 2'b10) begin failures++; $display("FAIL hold_next got=%b/%b want=0100/10", grant, {addr1, addr0}); end
            checks++; if (preempt !== 1'b0) begin failures++; $display("FAIL hold_preempt_pulse got=%b want=0", preempt); end
        end
`else
        for (int n = 0; n < 20; n++) begin
            tick();
            checks++; if (grant !== 4'b0001 || preempt !== 1'b0) begin failures++; $display("FAIL hold_keep n=%0d got=%b/%b want=0001/0", n, grant, preempt); end
        end
`endif
        req = 4'b0000;
        tick(); tick();
        $display("test_hold done grant=%b", grant);
    endtask

    task automatic test_async_reset();
        req = 4'b0010;
        tick(); tick(); tick();
        checks++; if (sel_valid !== 1'b1 || grant !== 4'b0010) begin failures++; $display("FAIL areset_pre got=%b/%b want=0010/1", grant, sel_valid); end
        #3;
        reset = 1'b1;
        #1;
        checks++; if (grant !== 4'b0000 || sel_valid !== 1'b0) begin failures++; $display("FAIL areset_now got=%b/%b want=0000/0", grant, sel_valid); end
        checks++; if ({addr1, addr0} !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL areset_addr got=%b/%b want=00/0", {addr1, addr0}, busy); end
        req = 4'b0000;
        tick();
        reset = 1'b0;
        req = 4'b1000;
        tick();
        checks++; if (grant !== 4'b1000 || {addr1, addr0} !== 2'b11) begin failures++; $display("FAIL areset_regrant got=%b/%b want=1000/11", grant, {addr1, addr0}); end
        req = 4'b0000;
        tick();
        req = 4'b0011;
        tick();
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL areset_wrap got=%b want=0001", grant); end
        req = 4'b0000;
        tick();
        $display("test_async_reset done grant=%b", grant);
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_single_grant();
        test_ptr_skip();
        test_settle_drop();
        test_hold();
        test_async_reset();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter sharing one 4:1 multiplexer (addr0/addr1 select, in0..in3 data) between four requesters.
- Requester k owns mux input k. The arbiter drives the mux select lines and grants the mux to one requester at a time.
- It waits a programmable settle time after each select change, because the mux gates need time to settle, and only then flags the output as valid.
- Sits between requester logic and the mux instance in the datapath.

Parameters:
- SETTLE_CYCLES, 1, clock cycles between a select change and sel_valid; range 0..15.
- MAX_HOLD, 8, maximum BUSY cycles per grant when MUX_ARB_TIMEOUT_EN is defined; range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  request vector; bit k = requester k wants mux input k.
- grant  output  4  one-hot grant; all zero when idle.
- addr0  output  1  mux select LSB (granted index bit 0).
- addr1  output  1  mux select MSB (granted index bit 1).
- sel_valid  output  1  mux output is settled and belongs to the granted requester.
- busy  output  1  high whenever grant is nonzero.
- preempt  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - grant=0000, addr1:addr0=00, sel_valid=0, busy=0, preempt=0.
  - State=IDLE, priority pointer ptr=0, all counters 0.
- Reset mid-operation aborts the grant with no completion cycle.
- Arbitration (IDLE only):
  - Search req starting at index ptr, then ptr+1, ptr+2, ptr+3, mod 4.
  - The first set bit wins. Simultaneous requests are resolved only by this rotation.
- IDLE, any req set at edge N:
  - At edge N+1: grant=onehot(idx), {addr1,addr0}=idx, settle counter=SETTLE_CYCLES, state=SETTLE.
  - If SETTLE_CYCLES=0, go to BUSY directly with sel_valid=1 at N+1.
- IDLE, req=0000: stay in IDLE. addr holds its last value; never return it to 00, to avoid mux glitches.
- SETTLE:
  - Decrement the counter each cycle. When it reaches 0: state=BUSY, sel_valid=1.
  - sel_valid therefore rises SETTLE_CYCLES+1 edges after the winning req is sampled.
- BUSY: the grant holds while req[idx]=1. Requests from other requesters are ignored.
- Release, req[idx]=0 seen in SETTLE or BUSY:
  - Next edge: grant=0000, sel_valid=0, ptr=(idx+1) mod 4, state=IDLE.
  - Minimum one idle cycle between grants.
- Dropping req during SETTLE abandons the grant; sel_valid never asserts, and ptr still advances.
- Invariants:
  - grant is always one-hot or zero.
  - sel_valid=1 implies busy=1.
  - addr changes only on the IDLE→SETTLE edge.
- Width rules:
  - ptr and idx are 2 bits and wrap 3→0.
  - The settle counter is 4 bits. The hold counter is 8 bits and saturates.

Optional Feature:
- Macro MUX_ARB_TIMEOUT_EN.
- Defined:
  - A hold counter increments on each BUSY cycle.
  - When the count reaches MAX_HOLD and any other req bit is set, the next edge does a forced release: grant=0000, sel_valid=0, preempt=1 for one cycle, ptr=(idx+1) mod 4, state=IDLE.
  - If no other request is pending, the counter saturates and the grant continues.
  - The counter clears on every new grant.
- Undefined: no hold counter; the grant lasts until req[idx] drops; preempt is tied to 0.

Decomposition:
- Package mux_arb_pkg:
  - NREQ=4, SEL_W=2.
  - State enum {IDLE, SETTLE, BUSY}.
  - Counter width constants SETTLE_W=4, HOLD_W=8.
- Sub-module rr_pick: combinational rotating-priority encoder; inputs req[3:0] and ptr[1:0]; outputs idx[1:0] and found.

Test Plan:
1. Reset released, SETTLE_CYCLES=1; req=0001 sampled at edge 2 → grant=0001, addr1:addr0=00 at edge 3; sel_valid=1 at edge 4.
2. req=1111 held; each grantee drops req 3 cycles after its sel_valid → grant order 0001, 0010, 0100, 1000, 0001; one idle cycle between grants.
3. After serving requester 1 (ptr=2), req=0011 → grant=0001, addr=00; requester 1 is not re-served first.
4. req=0100 granted, then req[2] dropped during SETTLE (SETTLE_CYCLES=3) → grant=0000 next edge; sel_valid never 1; ptr=3.
5. MUX_ARB_TIMEOUT_EN defined, MAX_HOLD=4; req0 held, req2 raised during BUSY:
   - After 4 BUSY cycles: preempt pulses, grant=0000, then grant=0100 with addr=10.
   - Macro undefined: grant stays 0001 indefinitely.
6. reset asserted asynchronously mid-BUSY (between clock edges) → grant=0000, sel_valid=0, addr=00 immediately; after release, req=1000 is granted with ptr having restarted at 0.
